mem_arbiter: RTL and testbench

//  Downstream of the data-cache stage and the fetch-stage icache: single shared main-memory port plus line-wide backing store.

---
 rtl/mem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared main-memory arbiter for dcache writebacks and d/i line fills
// One transaction at a time with fixed latency; writebacks queue ahead of reads in a small FIFO.

module mem_arbiter_wbuf #(
  parameter int AW    = 32,
  parameter int DW    = 256,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          empty_o,
  output logic          full_o,
  output logic          overflow_o,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          do_pop;
  logic          do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CW'(DEPTH));
  assign do_pop      = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push     = push_i && (!full_o || do_pop);
  assign overflow_o  = overflow_q;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
      if (push_i && full_o && !do_pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end
endmodule

module mem_arbiter #(
  parameter int WORD_SIZE   = 32,
  parameter int LINE_SIZE   = 256,
  parameter int MEM_LATENCY = 5,
  parameter int MEM_LINES   = 4096,
  parameter int WBUF_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d_req,
  input  logic [WORD_SIZE-1:0] d_req_addr,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_write_addr,
  input  logic [LINE_SIZE-1:0] d_write_data,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_req_addr,
  output logic                 d_res,
  output logic [WORD_SIZE-1:0] d_res_addr,
  output logic [LINE_SIZE-1:0] d_res_data,
  output logic                 i_res,
  output logic [WORD_SIZE-1:0] i_res_addr,
  output logic [LINE_SIZE-1:0] i_res_data,
  output logic                 wbuf_full,
  output logic                 wbuf_overflow
);
  localparam int OFF   = $clog2(LINE_SIZE / 8);
  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = $clog2(MEM_LATENCY);
  localparam logic [WORD_SIZE-1:0] OFF_MASK = WORD_SIZE'((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_DREAD = 2'd1, OP_IREAD = 2'd2} op_t;

  state_t               state_q;
  op_t                  op_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [LINE_SIZE-1:0] data_q;
  logic                 d_res_q;
  logic [WORD_SIZE-1:0] d_res_addr_q;
  logic [LINE_SIZE-1:0] d_res_data_q;
  logic                 i_res_q;
  logic [WORD_SIZE-1:0] i_res_addr_q;
  logic [LINE_SIZE-1:0] i_res_data_q;
  logic [LINE_SIZE-1:0] mem_q [MEM_LINES];

  logic                 wb_pop;
  logic                 wb_empty;
  logic [WORD_SIZE-1:0] wb_head_addr;
  logic [LINE_SIZE-1:0] wb_head_data;
  logic [IDX_W-1:0]     line_idx;

  // Upper address bits above the array size are ignored, so lines alias.
  assign line_idx = addr_q[OFF +: IDX_W];
  assign wb_pop   = (state_q == S_IDLE) && !wb_empty;

  mem_arbiter_wbuf #(
    .AW    (WORD_SIZE),
    .DW    (LINE_SIZE),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (d_write),
    .push_addr_i (d_write_addr),
    .push_data_i (d_write_data),
    .pop_i       (wb_pop),
    .empty_o     (wb_empty),
    .full_o      (wbuf_full),
    .overflow_o  (wbuf_overflow),
    .head_addr_o (wb_head_addr),
    .head_data_o (wb_head_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_WRITE;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      d_res_q      <= 1'b0;
      d_res_addr_q <= '0;
      d_res_data_q <= '0;
      i_res_q      <= 1'b0;
      i_res_addr_q <= '0;
      i_res_data_q <= '0;
    end else begin
      d_res_q <= 1'b0;
      i_res_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!wb_empty) begin
            op_q   <= OP_WRITE;
            addr_q <= wb_head_addr;
            data_q <= wb_head_data;
          end else if (d_req) begin
            op_q   <= OP_DREAD;
            addr_q <= d_req_addr;
          end else if (i_req) begin
            op_q   <= OP_IREAD;
            addr_q <= i_req_addr;
          end
          if (!wb_empty || d_req || i_req) begin
            cnt_q   <= CNT_W'(MEM_LATENCY - 2);
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Read data is captured entering RESP; nothing writes the array while BUSY.
          if (cnt_q == '0) begin
            state_q <= S_RESP;
            if (op_q == OP_DREAD) begin
              d_res_q      <= 1'b1;
              d_res_addr_q <= addr_q & ~OFF_MASK;
              d_res_data_q <= mem_q[line_idx];
            end
            if (op_q == OP_IREAD) begin
              i_res_q      <= 1'b1;
              i_res_addr_q <= addr_q & ~OFF_MASK;
              i_res_data_q <= mem_q[line_idx];
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Backing array survives reset; a write in its RESP cycle is dropped if rst is high.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_RESP && op_q == OP_WRITE) begin
      mem_q[line_idx] <= data_q;
    end
  end

  assign d_res      = d_res_q;
  assign d_res_addr = d_res_addr_q;
  assign d_res_data = d_res_data_q;
  assign i_res      = i_res_q;
  assign i_res_addr = i_res_addr_q;
  assign i_res_data = i_res_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter
// Transaction-level model predicts fills; a separate monitor pops and compares.

module tb_mem_arbiter;
  localparam int WS = 32, LS = 256, LAT = 5, LINES = 4096, DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_req, d_write, i_req;
  logic [WS-1:0] d_req_addr, d_write_addr, i_req_addr;
  logic [LS-1:0] d_write_data;
  logic          d_res, i_res, wbuf_full, wbuf_overflow;
  logic [WS-1:0] d_res_addr, i_res_addr;
  logic [LS-1:0] d_res_data, i_res_data;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(WS), .LINE_SIZE(LS), .MEM_LATENCY(LAT),
                .MEM_LINES(LINES), .WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_req_addr(d_req_addr),
    .d_write(d_write), .d_write_addr(d_write_addr), .d_write_data(d_write_data),
    .i_req(i_req), .i_req_addr(i_req_addr),
    .d_res(d_res), .d_res_addr(d_res_addr), .d_res_data(d_res_data),
    .i_res(i_res), .i_res_addr(i_res_addr), .i_res_data(i_res_data),
    .wbuf_full(wbuf_full), .wbuf_overflow(wbuf_overflow)
  );

  int checks = 0, failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned cyc; logic [WS-1:0] addr; logic [LS-1:0] data; } exp_t;
  typedef struct { logic [WS-1:0] addr; logic [LS-1:0] data; } wb_t;

  exp_t          d_exp[$], i_exp[$];
  wb_t           fifo_m[$];
  logic [LS-1:0] mem_m [int unsigned];
  bit            cm_v;
  int unsigned   cm_idx, cm_cyc, free_at;
  logic [LS-1:0] cm_data;
  bit            m_full, m_ovf, mon_en;
  bit            d_pend, i_pend, d_hold, i_hold;

  task automatic check(input string name, input logic [LS-1:0] got, input logic [LS-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int unsigned line_idx(input logic [WS-1:0] a);
    return (a / 32) % LINES;
  endfunction

  function automatic logic [WS-1:0] line_addr(input logic [WS-1:0] a);
    return a - (a % 32);
  endfunction

  function automatic logic [LS-1:0] mem_rd(input int unsigned idx);
    return mem_m.exists(idx) ? mem_m[idx] : '0;
  endfunction

  // One model cycle: memory is a single server, busy LAT+1 cycles per job.
  task automatic model_step();
    exp_t e;
    wb_t  w;
    bit   idle;
    if (cm_v && cm_cyc < cyc) begin
      mem_m[cm_idx] = cm_data;
      cm_v = 0;
    end
    idle = (cyc >= free_at);
    if (idle && fifo_m.size() > 0) begin
      w = fifo_m.pop_front();
      cm_v = 1; cm_idx = line_idx(w.addr); cm_data = w.data; cm_cyc = cyc + LAT;
      free_at = cyc + LAT + 1;
    end else if (idle && d_req) begin
      e.cyc = cyc + LAT; e.addr = line_addr(d_req_addr); e.data = mem_rd(line_idx(d_req_addr));
      d_exp.push_back(e);
      free_at = cyc + LAT + 1;
    end else if (idle && i_req) begin
      e.cyc = cyc + LAT; e.addr = line_addr(i_req_addr); e.data = mem_rd(line_idx(i_req_addr));
      i_exp.push_back(e);
      free_at = cyc + LAT + 1;
    end
    if (d_write) begin
      if (fifo_m.size() < DEPTH) fifo_m.push_back('{d_write_addr, d_write_data});
      else m_ovf = 1;
    end
    m_full = (fifo_m.size() == DEPTH);
  endtask

  task automatic model_reset();
    if (cm_v && cm_cyc < cyc) mem_m[cm_idx] = cm_data;
    cm_v = 0;
    fifo_m.delete();
    while (d_exp.size() > 0 && d_exp[$].cyc > cyc) void'(d_exp.pop_back());
    while (i_exp.size() > 0 && i_exp[$].cyc > cyc) void'(i_exp.pop_back());
    m_full = 0; m_ovf = 0;
    free_at = cyc + 1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      check("wbuf_full", LS'(wbuf_full), LS'(m_full));
      check("wbuf_overflow", LS'(wbuf_overflow), LS'(m_ovf));
      check("res_exclusive", LS'(d_res & i_res), '0);
      if (d_res) begin
        if (d_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL d_res_unexpected got addr=%0h at cycle %0d exp=no fill", d_res_addr, cyc);
        end else begin
          e = d_exp.pop_front();
          check("d_res_cycle", LS'(cyc), LS'(e.cyc));
          check("d_res_addr", LS'(d_res_addr), LS'(e.addr));
          check("d_res_data", d_res_data, e.data);
        end
      end
      if (i_res) begin
        if (i_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL i_res_unexpected got addr=%0h at cycle %0d exp=no fill", i_res_addr, cyc);
        end else begin
          e = i_exp.pop_front();
          check("i_res_cycle", LS'(cyc), LS'(e.cyc));
          check("i_res_addr", LS'(i_res_addr), LS'(e.addr));
          check("i_res_data", i_res_data, e.data);
        end
      end
      if (d_exp.size() > 0 && d_exp[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL d_res_missing got=none exp=cycle %0d", d_exp[0].cyc);
        void'(d_exp.pop_front());
      end
      if (i_exp.size() > 0 && i_exp[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL i_res_missing got=none exp=cycle %0d", i_exp[0].cyc);
        void'(i_exp.pop_front());
      end
    end
  end

  task automatic cycle_end();
    if (!rst) model_step();
    @(negedge clk); #1;
    d_write = 0;
    if (d_res) begin d_req = 0; d_pend = 0; d_hold = 1; end
    if (i_res) begin i_req = 0; i_pend = 0; i_hold = 1; end
  endtask

  task automatic req_d(input logic [WS-1:0] a);
    d_req = 1; d_req_addr = a; d_pend = 1;
  endtask

  task automatic req_i(input logic [WS-1:0] a);
    i_req = 1; i_req_addr = a; i_pend = 1;
  endtask

  task automatic wr(input logic [WS-1:0] a, input logic [LS-1:0] dat);
    d_write = 1; d_write_addr = a; d_write_data = dat;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((d_pend || i_pend || fifo_m.size() != 0 || cyc < free_at) && n < 200) begin
      cycle_end();
      n++;
    end
    check({name, "_drain"}, LS'(n < 200), LS'(1));
  endtask

  task automatic do_reset();
    rst = 1; d_req = 0; i_req = 0; d_write = 0;
    d_pend = 0; i_pend = 0;
    model_reset();
    @(negedge clk); #1;
    rst = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_res"}, LS'(d_res), '0);
    check({tag, "_i_res"}, LS'(i_res), '0);
    check({tag, "_d_res_addr"}, LS'(d_res_addr), '0);
    check({tag, "_i_res_addr"}, LS'(i_res_addr), '0);
    check({tag, "_d_res_data"}, d_res_data, '0);
    check({tag, "_i_res_data"}, i_res_data, '0);
    check({tag, "_wbuf_full"}, LS'(wbuf_full), '0);
    check({tag, "_wbuf_overflow"}, LS'(wbuf_overflow), '0);
  endtask

  function automatic logic [WS-1:0] rand_addr();
    logic [WS-1:0] a;
    a = WS'($urandom_range(0, 7) * 32 + $urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) a = a + WS'($urandom_range(1, 7)) * 32'h0002_0000;
    return a;
  endfunction

  function automatic logic [LS-1:0] rand_line();
    logic [LS-1:0] v;
    for (int k = 0; k < LS / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [LS-1:0] line_a, line_b, line_c;

  initial begin
    rst = 1; d_req = 0; i_req = 0; d_write = 0;
    d_req_addr = '0; i_req_addr = '0; d_write_addr = '0; d_write_data = '0;
    cm_v = 0; free_at = 0; m_full = 0; m_ovf = 0; mon_en = 0;
    d_pend = 0; i_pend = 0; d_hold = 0; i_hold = 0;
    line_a = rand_line(); line_b = rand_line(); line_c = rand_line();
    @(negedge clk); #1;
    do_reset();
    mon_en = 1;
    check_reset_outputs("reset");

    req_d(32'h0000_0104);
    drain("t1_cold_read");

    wr(32'h0000_0100, line_a);
    cycle_end();
    req_d(32'h0000_0100);
    drain("t2_write_then_read");

    req_d(32'h0000_0200);
    req_i(32'h0000_0300);
    drain("t3_priority");

    req_i(32'h0004_0100);
    drain("t6_alias");

    for (int n = 0; n < 1500; n++) begin
      if (d_hold) d_hold = 0;
      else if (!d_pend && $urandom_range(0, 2) == 0) req_d(rand_addr());
      if (i_hold) i_hold = 0;
      else if (!i_pend && $urandom_range(0, 2) == 0) req_i(rand_addr());
      if ($urandom_range(0, 4) == 0) wr(rand_addr(), rand_line());
      cycle_end();
    end
    drain("random");

    req_d(32'h0000_0020);
    cycle_end();
    for (int k = 0; k < 3; k++) begin
      wr(32'h0000_0040 + WS'(k * 32), rand_line());
      cycle_end();
    end
    check("t4_overflow_set", LS'(wbuf_overflow), LS'(1));
    drain("t4_overflow");
    check("t4_overflow_sticky", LS'(wbuf_overflow), LS'(1));

    wr(32'h0000_00e0, line_c);
    cycle_end();
    drain("t5_setup");
    wr(32'h0000_00e0, line_b);
    cycle_end();
    cycle_end();
    cycle_end();
    do_reset();
    check_reset_outputs("t5_after_rst");
    req_d(32'h0000_00e4);
    drain("t5_old_data");

    check("end_d_exp_empty", LS'(d_exp.size()), '0);
    check("end_i_exp_empty", LS'(i_exp.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
